// File: rtl/spw_babasu_rx_pkg.sv
// Shared types and constants for the SpaceWire RX drain controller.
// Contents:
//   rx_state_e      - drain FSM state encoding
//   RX_CTRL_BIT     - rx_data bit flagging a control token
//   RX_EOP / RX_EEP - values of rx_data[0] selecting the packet end marker
//   WORD_BYTES_MAX  - bytes per packed output word
package spw_babasu_rx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StCapture,
    StPresent
  } rx_state_e;

  localparam int unsigned RX_CTRL_BIT    = 8;
  localparam logic        RX_EOP         = 1'b0;
  localparam logic        RX_EEP         = 1'b1;
  localparam int unsigned WORD_BYTES_MAX = 4;

endpackage

// File: rtl/spw_babasu_rx_packer.sv
// Byte-lane accumulator for the RX drain controller. It packs received bytes
// little-endian into a 32-bit word, counts them and latches end markers.
// Ports:
//   clk_i        - system clock
//   rst_ni       - asynchronous active-low reset
//   capture_i    - sample rx_data_i this cycle
//   rx_data_i    - FIFO word: [8]=control token, [0] selects EOP/EEP for tokens
//   clear_i      - discard the word (after handshake); wins over capture_i
//   word_data_o  - packed bytes, first byte in [7:0], unused lanes 0
//   byte_cnt_o   - number of bytes held, 0..4
//   eop_o/eep_o  - word terminated by EOP / EEP
module spw_babasu_rx_packer
  import spw_babasu_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_i,
  input  logic [8:0]  rx_data_i,
  input  logic        clear_i,
  output logic [31:0] word_data_o,
  output logic [2:0]  byte_cnt_o,
  output logic        eop_o,
  output logic        eep_o
);

  logic [31:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        eop_q, eop_d;
  logic        eep_q, eep_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    eop_d = eop_q;
    eep_d = eep_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
      eop_d = 1'b0;
      eep_d = 1'b0;
    end else if (capture_i) begin
      if (rx_data_i[RX_CTRL_BIT]) begin
        eop_d = (rx_data_i[0] == RX_EOP);
        eep_d = (rx_data_i[0] == RX_EEP);
      end else if (cnt_q < 3'(WORD_BYTES_MAX)) begin
        // Guard keeps the counter from ever passing 4 or wrapping.
        acc_d[{cnt_q[1:0], 3'b000} +: 8] = rx_data_i[7:0];
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      eop_q <= 1'b0;
      eep_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      eop_q <= eop_d;
      eep_q <= eep_d;
    end
  end

  assign word_data_o = acc_q;
  assign byte_cnt_o  = cnt_q;
  assign eop_o       = eop_q;
  assign eep_o       = eep_q;

endmodule

// File: rtl/spw_babasu_rx_drain_ctrl.sv
// Drains the SpaceWire RX FIFO whenever it is non-empty and packs the bytes
// into 32-bit words presented on a valid/ready stream with an interrupt.
// Optional feature: define SPW_RX_DRAIN_TIMEOUT_EN to flush a partial word
// after TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES >= 2).
// Ports:
//   clk_i          - system clock
//   reset_ni       - asynchronous active-low reset
//   enable_i       - 1 = drain; 0 = finish the byte in flight, then stop reading
//   rx_empty_i     - RX FIFO empty flag
//   rx_read_o      - single-cycle FIFO read strobe
//   rx_data_i      - FIFO output, valid the cycle after rx_read_o
//   word_valid_o   - packed word available
//   word_ready_i   - consumer accepts on word_valid_o && word_ready_i
//   word_data_o    - packed bytes, first byte in [7:0]
//   word_bytes_o   - valid data bytes, 0..4
//   word_eop_o     - word terminated by EOP
//   word_eep_o     - word terminated by EEP
//   irq_o          - level interrupt, equal to word_valid_o
module spw_babasu_rx_drain_ctrl
  import spw_babasu_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  input  logic        rx_empty_i,
  output logic        rx_read_o,
  input  logic [8:0]  rx_data_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_data_o,
  output logic [2:0]  word_bytes_o,
  output logic        word_eop_o,
  output logic        word_eep_o,
  output logic        irq_o
);

  rx_state_e state_q, state_d;

  logic       capture;
  logic       handshake;
  logic       fetch_ok;
  logic       last_lane;
  logic       tmo_fire;
  logic [2:0] byte_cnt;

  assign capture   = (state_q == StCapture);
  assign handshake = (state_q == StPresent) && word_ready_i;
  assign fetch_ok  = enable_i && !rx_empty_i;
  // Capturing a data byte into the final lane completes the word.
  assign last_lane = (byte_cnt == 3'(WORD_BYTES_MAX - 1));

  spw_babasu_rx_packer u_packer (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .capture_i   (capture),
    .rx_data_i   (rx_data_i),
    .clear_i     (handshake),
    .word_data_o (word_data_o),
    .byte_cnt_o  (byte_cnt),
    .eop_o       (word_eop_o),
    .eep_o       (word_eep_o)
  );

`ifdef SPW_RX_DRAIN_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_run;

  // Counts idle cycles while a partial word waits for more bytes.
  assign tmo_run  = (state_q == StIdle) && (byte_cnt != 3'd0) && !fetch_ok;
  assign tmo_fire = tmo_run && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (capture || handshake) begin
      tmo_d = '0;
    end else if (tmo_run && !tmo_fire) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_ok) begin
          state_d = StFetch;
        end else if (tmo_fire) begin
          state_d = StPresent;
        end
      end
      StFetch: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (rx_data_i[RX_CTRL_BIT] || last_lane) begin
          state_d = StPresent;
        end else if (fetch_ok) begin
          state_d = StFetch;
        end else begin
          state_d = StIdle;
        end
      end
      StPresent: begin
        if (word_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign rx_read_o    = (state_q == StFetch);
  assign word_valid_o = (state_q == StPresent);
  assign word_bytes_o = byte_cnt;
  assign irq_o        = word_valid_o;

endmodule

// File: tb/tb_spw_babasu_rx_drain_ctrl.sv
module tb_spw_babasu_rx_drain_ctrl;

  localparam int unsigned TmoCycles = 8;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        enable_i;
  logic        rx_empty_i;
  logic        rx_read_o;
  logic [8:0]  rx_data_i;
  logic        word_valid_o;
  logic        word_ready_i;
  logic [31:0] word_data_o;
  logic [2:0]  word_bytes_o;
  logic        word_eop_o;
  logic        word_eep_o;
  logic        irq_o;

  spw_babasu_rx_drain_ctrl #(
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .enable_i     (enable_i),
    .rx_empty_i   (rx_empty_i),
    .rx_read_o    (rx_read_o),
    .rx_data_i    (rx_data_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_bytes_o (word_bytes_o),
    .word_eop_o   (word_eop_o),
    .word_eep_o   (word_eep_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        eop;
    logic        eep;
  } word_t;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  fifo_q[$];
  word_t       exp_q[$];
  logic [7:0]  m_bytes[$];
  int unsigned cyc = 0;
  int unsigned read_cyc[$];
  int unsigned hs_cyc = 0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word closes on the 4th byte or on an end marker.
  function automatic word_t close_word(input logic eop, input logic eep);
    word_t w;
    w.data  = '0;
    w.bytes = 3'(m_bytes.size());
    foreach (m_bytes[i]) w.data[8*i +: 8] = m_bytes[i];
    w.eop = eop;
    w.eep = eep;
    m_bytes.delete();
    return w;
  endfunction

  task automatic push_item(input logic [8:0] it);
    fifo_q.push_back(it);
    if (it[8]) begin
      exp_q.push_back(close_word(it[0] == 1'b0, it[0] == 1'b1));
    end else begin
      m_bytes.push_back(it[7:0]);
      if (m_bytes.size() == 4) exp_q.push_back(close_word(1'b0, 1'b0));
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drained(input int unsigned budget, input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || word_valid_o) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + fifo_q.size()), 32'd0);
  endtask

  // FIFO model: one-cycle read latency.
  initial begin : fifo_proc
    logic rd;
    rx_data_i  = '0;
    rx_empty_i = 1'b1;
    forever begin
      @(negedge clk_i);
      rd = rx_read_o;
      @(posedge clk_i);
      #1;
      if (rd && fifo_q.size() > 0) rx_data_i = fifo_q.pop_front();
      rx_empty_i = (fifo_q.size() == 0);
    end
  end

  initial begin : ready_proc
    forever begin
      tick();
      if (rand_ready) word_ready_i = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: scoreboard pops on each handshake; protocol checks every cycle.
  initial begin : monitor
    word_t snap;
    word_t exp_w;
    bit    hold_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!mon_en) begin
        hold_prev = 1'b0;
        continue;
      end
      check("irq_eq_valid", 32'(irq_o), 32'(word_valid_o));
      if (rx_read_o) begin
        check("read_while_presenting", 32'(word_valid_o), 32'd0);
        check("read_fifo_nonempty", 32'(fifo_q.size() > 0), 32'd1);
        if (read_cyc.size() > 0) check("read_gap_ge2", 32'(cyc - read_cyc[$] >= 2), 32'd1);
        read_cyc.push_back(cyc);
      end
      if (hold_prev) begin
        check("hold_valid", 32'(word_valid_o), 32'd1);
        check("hold_data", word_data_o, snap.data);
        check("hold_bytes", 32'(word_bytes_o), 32'(snap.bytes));
        check("hold_marks", {30'd0, word_eop_o, word_eep_o}, {30'd0, snap.eop, snap.eep});
      end
      hold_prev  = word_valid_o && !word_ready_i;
      snap.data  = word_data_o;
      snap.bytes = word_bytes_o;
      snap.eop   = word_eop_o;
      snap.eep   = word_eep_o;
      if (word_valid_o && word_ready_i) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_word_bytes", 32'(word_bytes_o), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("word_data", word_data_o, exp_w.data);
          check("word_bytes", 32'(word_bytes_o), 32'(exp_w.bytes));
          check("word_eop", 32'(word_eop_o), 32'(exp_w.eop));
          check("word_eep", 32'(word_eep_o), 32'(exp_w.eep));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string name);
    check({name, "_rx_read"}, 32'(rx_read_o), 32'd0);
    check({name, "_valid"}, 32'(word_valid_o), 32'd0);
    check({name, "_data"}, word_data_o, 32'd0);
    check({name, "_bytes"}, 32'(word_bytes_o), 32'd0);
    check({name, "_marks"}, {30'd0, word_eop_o, word_eep_o}, 32'd0);
    check({name, "_irq"}, 32'(irq_o), 32'd0);
  endtask

  initial begin : stimulus
    int unsigned n;
    int unsigned nreads;
    int unsigned seen;
    logic [8:0]  it;

    reset_ni     = 1'b0;
    enable_i     = 1'b0;
    word_ready_i = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) tick();
    reset_ni = 1'b1;
    mon_en   = 1'b1;
    tick();

    // Four bytes, consumer always ready: reads exactly 2 cycles apart.
    enable_i     = 1'b1;
    word_ready_i = 1'b1;
    read_cyc.delete();
    push_item(9'h011); push_item(9'h022); push_item(9'h033); push_item(9'h044);
    wait_drained(100, "four_bytes");
    check("four_bytes_reads", 32'(read_cyc.size()), 32'd4);
    for (int i = 1; i < 4 && i < read_cyc.size(); i++)
      check("four_bytes_gap", read_cyc[i] - read_cyc[i-1], 32'd2);

    // Two bytes then EOP; then a bare EEP.
    push_item(9'h0AA); push_item(9'h0BB); push_item(9'h100);
    wait_drained(100, "eop_word");
    push_item(9'h101);
    wait_drained(100, "bare_eep");

    // Backpressure: no reads and stable outputs while word_ready is low.
    word_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) push_item(9'(8'h60 + i));
    n = 0;
    while (!word_valid_o && n < 100) begin tick(); n++; end
    check("bp_valid_seen", 32'(word_valid_o), 32'd1);
    nreads = read_cyc.size();
    repeat (10) tick();
    check("bp_no_reads", 32'(read_cyc.size()), 32'(nreads));
    word_ready_i = 1'b1;
    n = 0;
    while (read_cyc.size() == nreads && n < 20) begin tick(); n++; end
    check("bp_read_after_hs", read_cyc[$] - hs_cyc, 32'd2);
    wait_drained(100, "backpressure");

    // Single byte followed by an idle FIFO.
    push_item(9'h05A);
`ifdef SPW_RX_DRAIN_TIMEOUT_EN
    exp_q.push_back(close_word(1'b0, 1'b0));
    wait_drained(TmoCycles + 20, "timeout_flush");
`else
    seen = 0;
    repeat (30) begin
      tick();
      if (word_valid_o) seen++;
    end
    check("no_timeout_word", seen, 32'd0);
    push_item(9'h100);
    wait_drained(100, "held_partial");
`endif

    // Reset while capturing the 4th byte with 3 bytes held.
    read_cyc.delete();
    for (int i = 1; i <= 4; i++) fifo_q.push_back(9'(i));
    n = 0;
    while (read_cyc.size() < 4 && n < 100) begin tick(); n++; end
    check("rst_mid_reads", 32'(read_cyc.size()), 32'd4);
    mon_en   = 1'b0;
    reset_ni = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    tick();
    reset_ni = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    m_bytes.delete();
    tick();
    mon_en = 1'b1;
    read_cyc.delete();
    push_item(9'h0E1); push_item(9'h0E2); push_item(9'h0E3); push_item(9'h0E4);
    wait_drained(100, "after_reset");

    // Randomized groups, each ending on a word boundary.
    rand_ready = 1'b1;
    for (int g = 0; g < 80; g++) begin
      n = $urandom_range(0, 4);
      for (int b = 0; b < n; b++) begin
        it = {1'b0, 8'($urandom)};
        push_item(it);
      end
      if (n != 4) push_item({1'b1, 7'd0, 1'($urandom_range(0, 1))});
`ifndef SPW_RX_DRAIN_TIMEOUT_EN
      enable_i = ($urandom_range(0, 3) != 0);
`endif
      repeat ($urandom_range(0, 6)) tick();
    end
    enable_i = 1'b1;
    repeat (20) tick();
    rand_ready   = 1'b0;
    tick();
    word_ready_i = 1'b1;
    wait_drained(5000, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
